tusca_dht11_leitor: RTL and testbench
=====================================

// Module: tusca_dht11_leitor
// PURPOSE
//  Responder to the control unit's measurement request: on medir_dht11 it runs the DHT11 single-wire
//  transaction (host start pulse, sensor response, 40 data bits), checks the checksum and returns
//  humidity/temperature with a one-cycle pronto_medida pulse. Sits between the TUSCA control unit and the pad.
// PARAMETERS
//  T_START      900_000  cycles the host drives the line low (18 ms @ 50 MHz)
//  T_BIT_LIMIAR 2_500    high-pulse length (cycles) at/above which a bit reads as 1 (50 us)
//  T_TIMEOUT    10_000   max cycles in any wait-for-edge state before erro_timeout (200 us)
//  CW           20       width of the internal cycle counter; must hold T_START
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-high
//  medir_dht11    in   1   start request; sampled only in OCIOSO
//  dht_in         in   1   pad input (asynchronous, pulled up externally)
//  dht_oe         out  1   1 = drive pad low; 0 = release (open drain)
//  pronto_medida  out  1   one-cycle pulse, transaction finished (success or error)
//  umidade        out  16  {integer byte, decimal byte}, updated only on success
//  temperatura    out  16  {integer byte, decimal byte}, updated only on success
//  erro_checksum  out  1   valid with pronto_medida; held until next medir_dht11 is accepted
//  erro_timeout   out  1   valid with pronto_medida; held until next medir_dht11 is accepted
// BEHAVIOUR
//  - dht_in passes a 2-FF synchroniser (reset value 1); all edges below refer to the synchronised signal s.
//  - Reset: state OCIOSO, dht_oe=0, pronto_medida=0, umidade=0, temperatura=0, both erro=0,
//    counter=0, bit index=0, shift reg=0. Reset mid-transaction releases the line the next cycle.
//  - States/transitions (counter cleared on every state change):
//    OCIOSO: medir_dht11=1 -> INICIO; clear erro flags.
//    INICIO: dht_oe=1; counter reaches T_START-1 -> LIBERA.
//    LIBERA: dht_oe=0; s=0 -> RESP_BAIXO.
//    RESP_BAIXO: s=1 -> RESP_ALTO.
//    RESP_ALTO: s=0 -> BIT_BAIXO.
//    BIT_BAIXO: s=1 -> BIT_ALTO.
//    BIT_ALTO: counts cycles with s=1; on s=0, shift in (count>=T_BIT_LIMIAR), MSB first.
//      After the 40th bit -> CONFERE, else -> BIT_BAIXO.
//    CONFERE: sum of bytes [39:32]+[31:24]+[23:16]+[15:8] mod 256 == [7:0]:
//      equal -> umidade=[39:24], temperatura=[23:8]; else erro_checksum=1. -> FIM.
//    FIM: pronto_medida=1 for exactly this cycle -> OCIOSO.
//  - Timeout: in LIBERA, RESP_*, BIT_* a counter value of T_TIMEOUT-1 without the awaited edge
//    sets erro_timeout=1 and goes to FIM; outputs keep previous values.
//  - Latency: pronto_medida no earlier than T_START + sensor frame; exactly one pulse per accepted request.
//  - medir_dht11 outside OCIOSO is ignored (no queueing). medir_dht11 high in FIM is not accepted until OCIOSO.
//  - Counter saturates, never wraps; BIT_ALTO count saturates at T_TIMEOUT.
//  - dht_oe is 1 only in INICIO.
// TESTING (bench uses T_START=20, T_BIT_LIMIAR=10, T_TIMEOUT=40; sensor model drives dht_in)
//  1. Frame 0x37,0x00,0x19,0x05,0x55 -> pronto_medida 1 cycle, umidade=0x3700, temperatura=0x1905, erros=0.
//  2. Same frame, checksum 0x56 -> pronto, erro_checksum=1, umidade/temperatura keep prior values.
//  3. No sensor response (dht_in stays 1) -> dht_oe high exactly 20 cycles, pronto at 40 cycles after release, erro_timeout=1.
//  4. Sensor stops after 12 bits (line held high) -> erro_timeout=1 40 cycles later, exactly one pronto.
//  5. medir_dht11 pulsed during BIT_ALTO -> ignored; exactly one pronto, next request works normally.
//  6. reset asserted in INICIO -> dht_oe=0 next cycle, all outputs at reset values, no pronto.

Source files
------------

// File: rtl/tusca_dht11_leitor_if.sv
// Request/result bundle between the TUSCA control unit (master) and the DHT11 reader (slave).
// The reader answers one medir_dht11 request with a single pronto_medida pulse and its results.
interface tusca_dht11_leitor_if;
    logic        medir_dht11;
    logic        pronto_medida;
    logic [15:0] umidade;
    logic [15:0] temperatura;
    logic        erro_checksum;
    logic        erro_timeout;

    modport master (
        output medir_dht11,
        input  pronto_medida, umidade, temperatura, erro_checksum, erro_timeout
    );

    modport slave (
        input  medir_dht11,
        output pronto_medida, umidade, temperatura, erro_checksum, erro_timeout
    );
endinterface

// File: rtl/tusca_dht11_leitor.sv
// Purpose: runs one DHT11 single-wire transaction per request and returns checked humidity/temperature.
// Latency: pronto_medida no earlier than T_START + sensor frame; timeouts bound every wait to T_TIMEOUT.
// Backpressure: none; requests arriving outside OCIOSO are dropped, one pronto pulse per accepted request.
module tusca_dht11_leitor #(
    parameter int T_START      = 900_000,
    parameter int T_BIT_LIMIAR = 2_500,
    parameter int T_TIMEOUT    = 10_000,
    parameter int CW           = 20
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dht_in,
    output logic                   dht_oe,
    tusca_dht11_leitor_if.slave    ctl
);

    typedef enum logic [3:0] {
        OCIOSO, INICIO, LIBERA, RESP_BAIXO, RESP_ALTO,
        BIT_BAIXO, BIT_ALTO, CONFERE, FIM
    } estado_t;

    localparam logic [CW-1:0] LIM_START = CW'(T_START - 1);
    localparam logic [CW-1:0] LIM_ESPERA = CW'(T_TIMEOUT - 1);
    localparam logic [CW-1:0] LIM_BIT = CW'(T_BIT_LIMIAR);

    estado_t        estado;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_sat;
    logic [5:0]     bit_idx;
    logic [39:0]    shift;
    logic           s_meta;
    logic           s;
    logic           oe_r;
    logic           pronto_r;
    logic [15:0]    umid_r;
    logic [15:0]    temp_r;
    logic           erro_ck_r;
    logic           erro_to_r;
    logic [7:0]     soma;
    logic           estourou;

    assign cnt_sat  = (cnt == '1) ? cnt : cnt + CW'(1);
    assign estourou = (cnt == LIM_ESPERA);
    assign soma     = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];

    assign dht_oe            = oe_r;
    assign ctl.pronto_medida = pronto_r;
    assign ctl.umidade       = umid_r;
    assign ctl.temperatura   = temp_r;
    assign ctl.erro_checksum = erro_ck_r;
    assign ctl.erro_timeout  = erro_to_r;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado    <= OCIOSO;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            s_meta    <= 1'b1;
            s         <= 1'b1;
            oe_r      <= 1'b0;
            pronto_r  <= 1'b0;
            umid_r    <= '0;
            temp_r    <= '0;
            erro_ck_r <= 1'b0;
            erro_to_r <= 1'b0;
        end else begin
            s_meta   <= dht_in;
            s        <= s_meta;
            pronto_r <= 1'b0;
            cnt      <= cnt_sat;

            case (estado)
                OCIOSO: begin
                    cnt <= '0;
                    if (ctl.medir_dht11) begin
                        estado    <= INICIO;
                        oe_r      <= 1'b1;
                        erro_ck_r <= 1'b0;
                        erro_to_r <= 1'b0;
                        bit_idx   <= '0;
                        shift     <= '0;
                    end
                end
                INICIO: begin
                    if (cnt == LIM_START) begin
                        estado <= LIBERA;
                        oe_r   <= 1'b0;
                        cnt    <= '0;
                    end
                end
                LIBERA, RESP_BAIXO, RESP_ALTO, BIT_BAIXO: begin
                    // Each wait state looks for one specific level on the synchronised line.
                    if ((estado == RESP_BAIXO || estado == BIT_BAIXO) ? s : !s) begin
                        cnt <= '0;
                        case (estado)
                            LIBERA:     estado <= RESP_BAIXO;
                            RESP_BAIXO: estado <= RESP_ALTO;
                            RESP_ALTO:  estado <= BIT_BAIXO;
                            default:    estado <= BIT_ALTO;
                        endcase
                    end else if (estourou) begin
                        estado    <= FIM;
                        pronto_r  <= 1'b1;
                        erro_to_r <= 1'b1;
                        cnt       <= '0;
                    end
                end
                BIT_ALTO: begin
                    if (!s) begin
                        // High-time length decides the bit value; bits arrive MSB first.
                        shift   <= {shift[38:0], (cnt >= LIM_BIT)};
                        bit_idx <= bit_idx + 6'd1;
                        estado  <= (bit_idx == 6'd39) ? CONFERE : BIT_BAIXO;
                        cnt     <= '0;
                    end else if (estourou) begin
                        estado    <= FIM;
                        pronto_r  <= 1'b1;
                        erro_to_r <= 1'b1;
                        cnt       <= '0;
                    end
                end
                CONFERE: begin
                    if (soma == shift[7:0]) begin
                        umid_r <= shift[39:24];
                        temp_r <= shift[23:8];
                    end else begin
                        erro_ck_r <= 1'b1;
                    end
                    estado   <= FIM;
                    pronto_r <= 1'b1;
                    cnt      <= '0;
                end
                FIM: begin
                    estado <= OCIOSO;
                    cnt    <= '0;
                end
                default: begin
                    estado <= OCIOSO;
                    oe_r   <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tusca_dht11_leitor.sv
// Bench for tusca_dht11_leitor: a cycle-level DHT11 sensor model drives the pad while a
// frame-level reference (checksum rule, held results) predicts every transaction outcome.
module tb_tusca_dht11_leitor;
    localparam int TS = 20;
    localparam int TB = 10;
    localparam int TT = 40;

    logic clock = 1'b0;
    logic reset;
    logic dht_in;
    logic dht_oe;

    tusca_dht11_leitor_if ctl();

    tusca_dht11_leitor #(
        .T_START(TS), .T_BIT_LIMIAR(TB), .T_TIMEOUT(TT), .CW(20)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .dht_in (dht_in),
        .dht_oe (dht_oe),
        .ctl    (ctl)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observation of pad drive and completion pulses, sampled away from the active edge.
    int          ncyc = 0;
    int          oe_hi = 0;
    int          pronto_n = 0;
    int          last_oe_cyc = 0;
    int          pronto_cyc = 0;
    logic        snap_ck = 1'b0;
    logic        snap_to = 1'b0;

    always @(negedge clock) begin
        ncyc <= ncyc + 1;
        if (dht_oe) begin
            oe_hi       <= oe_hi + 1;
            last_oe_cyc <= ncyc;
        end
        if (ctl.pronto_medida) begin
            pronto_n   <= pronto_n + 1;
            pronto_cyc <= ncyc;
            snap_ck    <= ctl.erro_checksum;
            snap_to    <= ctl.erro_timeout;
        end
    end

    // Reference state: results only change on a frame whose checksum holds.
    logic [15:0] exp_u = '0;
    logic [15:0] exp_t = '0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        dht_in = v;
        repeat (n) tick();
    endtask

    task automatic pulse_medir();
        ctl.medir_dht11 = 1'b1;
        tick();
        ctl.medir_dht11 = 1'b0;
    endtask

    function automatic logic [39:0] make_frame(input bit good, input bit force_b37);
        logic [7:0] b [4];
        logic [7:0] cs;
        logic [39:0] f;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        if (force_b37) b[0][5] = 1'b1;
        cs = b[0] + b[1] + b[2] + b[3];
        if (!good) cs = cs + 8'($urandom_range(1, 255));
        f = {b[0], b[1], b[2], b[3], cs};
        return f;
    endfunction

    // Sensor: waits for the host start pulse, answers, then sends nbits bits (MSB first).
    // A short frame leaves the line high in the middle of the last bit's high phase.
    task automatic sensor(input logic [39:0] frame, input int nbits, input int poke_bit,
                          output int last_h);
        int w;
        int h;
        w = 0;
        last_h = 0;
        while (!dht_oe && w < 100) begin tick(); w++; end
        while (dht_oe && w < 200) begin tick(); w++; end
        check_val("start_pulse_released", (w < 200), 1);
        drive(1'b1, $urandom_range(2, 5));
        drive(1'b0, $urandom_range(4, 12));
        drive(1'b1, $urandom_range(4, 12));
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, $urandom_range(2, 8));
            h = frame[39 - i] ? $urandom_range(14, 20) : $urandom_range(2, 6);
            last_h = h;
            if (i == poke_bit) begin
                dht_in = 1'b1;
                repeat (6) tick();
                pulse_medir();
                repeat (h - 7) tick();
            end else begin
                drive(1'b1, h);
            end
        end
        if (nbits == 40) drive(1'b0, $urandom_range(3, 6));
        dht_in = 1'b1;
    endtask

    task automatic do_frame(input string tag, input logic [39:0] frame, input int poke_bit);
        int base;
        int oe_base;
        int w;
        int last_h;
        int sum;
        bit good;
        base    = pronto_n;
        oe_base = oe_hi;
        sum  = int'(frame[39:32]) + int'(frame[31:24]) + int'(frame[23:16]) + int'(frame[15:8]);
        good = ((sum % 256) == int'(frame[7:0]));
        if (good) begin
            exp_u = frame[39:24];
            exp_t = frame[23:8];
        end
        pulse_medir();
        sensor(frame, 40, poke_bit, last_h);
        w = 0;
        while (pronto_n == base && w < 200) begin tick(); w++; end
        repeat (10) tick();
        check_val({tag, "_pronto_count"}, pronto_n - base, 1);
        check_val({tag, "_oe_cycles"}, oe_hi - oe_base, TS);
        check_val({tag, "_erro_ck"}, snap_ck, !good);
        check_val({tag, "_erro_to"}, snap_to, 0);
        check_val({tag, "_umidade"}, ctl.umidade, exp_u);
        check_val({tag, "_temperatura"}, ctl.temperatura, exp_t);
        check_val({tag, "_ck_held"}, ctl.erro_checksum, !good);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int oe_base;
        int w;
        int n;
        int last_h;
        logic [39:0] f;

        dht_in = 1'b1;
        ctl.medir_dht11 = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        check_val("rst_oe", dht_oe, 0);
        check_val("rst_pronto", ctl.pronto_medida, 0);
        check_val("rst_umidade", ctl.umidade, 0);
        check_val("rst_temperatura", ctl.temperatura, 0);
        check_val("rst_erro_ck", ctl.erro_checksum, 0);
        check_val("rst_erro_to", ctl.erro_timeout, 0);
        reset = 1'b0;
        repeat (3) tick();

        // Known good frame, then the literal results.
        do_frame("t1", 40'h37_00_19_05_55, -1);
        check_val("t1_umidade_lit", ctl.umidade, 16'h3700);
        check_val("t1_temperatura_lit", ctl.temperatura, 16'h1905);

        // A different good frame first, so a bad checksum must visibly keep these.
        f = make_frame(1'b1, 1'b0);
        do_frame("pre_t2", f, -1);
        do_frame("t2", 40'h37_00_19_05_56, -1);

        // No sensor at all: line stays released-high after the start pulse.
        base = pronto_n;
        oe_base = oe_hi;
        pulse_medir();
        w = 0;
        while (pronto_n == base && w < 300) begin tick(); w++; end
        repeat (5) tick();
        check_val("t3_pronto_count", pronto_n - base, 1);
        check_val("t3_oe_cycles", oe_hi - oe_base, TS);
        check_val("t3_release_to_pronto", pronto_cyc - last_oe_cyc - 1, TT);
        check_val("t3_erro_to", snap_to, 1);
        check_val("t3_erro_ck", snap_ck, 0);
        check_val("t3_umidade", ctl.umidade, exp_u);
        check_val("t3_temperatura", ctl.temperatura, exp_t);

        // Sensor stalls high during bit 12: 2 sync stages + 1 detect cycle + T_TIMEOUT.
        base = pronto_n;
        f = make_frame(1'b1, 1'b0);
        pulse_medir();
        sensor(f, 12, -1, last_h);
        n = 0;
        while (!ctl.pronto_medida && n < 200) begin tick(); n++; end
        check_val("t4_rise_to_pronto", n + last_h, TT + 3);
        repeat (10) tick();
        check_val("t4_pronto_count", pronto_n - base, 1);
        check_val("t4_erro_to", ctl.erro_timeout, 1);
        check_val("t4_erro_ck", ctl.erro_checksum, 0);
        check_val("t4_umidade", ctl.umidade, exp_u);
        check_val("t4_temperatura", ctl.temperatura, exp_t);

        // Extra request while a '1' bit is high must be dropped; the next one still works.
        f = make_frame(1'b1, 1'b1);
        do_frame("t5", f, 2);
        f = make_frame(1'b1, 1'b0);
        do_frame("t5_next", f, -1);

        // Reset while driving the start pulse.
        base = pronto_n;
        pulse_medir();
        repeat (4) tick();
        check_val("t6_oe_in_inicio", dht_oe, 1);
        reset = 1'b1;
        tick();
        check_val("t6_oe_after_reset", dht_oe, 0);
        check_val("t6_umidade", ctl.umidade, 0);
        check_val("t6_temperatura", ctl.temperatura, 0);
        check_val("t6_erro_ck", ctl.erro_checksum, 0);
        check_val("t6_erro_to", ctl.erro_timeout, 0);
        check_val("t6_pronto", ctl.pronto_medida, 0);
        reset = 1'b0;
        exp_u = '0;
        exp_t = '0;
        repeat (60) tick();
        check_val("t6_no_pronto", pronto_n - base, 0);

        // Randomized frames, roughly a third with a corrupted checksum.
        for (int k = 0; k < 10; k++) begin
            f = make_frame(($urandom_range(0, 2) != 0), 1'b0);
            do_frame($sformatf("rnd%0d", k), f, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
